// File: rtl/sipo_rx_reg_pkg.sv
// Shared constants and types for the serial-in / parallel-out receiver.
// Bit-order selectors, holding-register state encoding, counter sizing helper.
package sipo_rx_reg_pkg;

  localparam bit MSB_FIRST_ORD = 1'b1;
  localparam bit LSB_FIRST_ORD = 1'b0;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  // Width of a counter that indexes bits 0..width-1 (never narrower than 1).
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_rx_reg_if.sv
// Serial input and parallel valid/ready output bundle of the receiver.
// master drives the serial link and consumes words; slave is the receiver.
interface sipo_rx_reg_if #(
  parameter int WIDTH = 4
);
  import sipo_rx_reg_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic             ser_in;
  logic             ser_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output ser_in, ser_valid, word_ready, ovr_clr,
    input  word_out, word_valid, bit_cnt, overrun
  );

  modport slave (
    input  ser_in, ser_valid, word_ready, ovr_clr,
    output word_out, word_valid, bit_cnt, overrun
  );

endinterface

// File: rtl/sipo_rx_reg_hold_reg.sv
// WIDTH-bit parallel-load register: per-bit load mux feeding a DFF with
// synchronous active-high reset.
module sipo_rx_reg_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic bit_d;
    assign bit_d = load_i ? d_i[b] : q_q[b];
    always_ff @(posedge clk) begin
      if (rst) q_q[b] <= 1'b0;
      else     q_q[b] <= bit_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sipo_rx_reg.sv
// Serial-in / parallel-out receiver: shifts one bit per ser_valid strobe and
// offers each completed word through a one-deep valid/ready holding register.
module sipo_rx_reg
  import sipo_rx_reg_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = MSB_FIRST_ORD
) (
  input  logic         clk,
  input  logic         rst,
  sipo_rx_reg_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  hold_state_e      st_q;
  logic             ovr_q;
  logic             comp;
  logic             load;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    comp  = bus.ser_valid && (cnt_q == LAST_CNT);
    if (bus.ser_valid) begin
      if (MSB_FIRST == MSB_FIRST_ORD) sh_d = {sh_q[WIDTH-2:0], bus.ser_in};
      else                            sh_d = {bus.ser_in, sh_q[WIDTH-1:1]};
      cnt_d = comp ? '0 : cnt_q + CW'(1);
    end
  end

  // A completed word is taken when the holder is free or drained this cycle.
  assign load = comp && ((st_q == HOLD_EMPTY) || bus.word_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
      st_q  <= HOLD_EMPTY;
      ovr_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      case (st_q)
        HOLD_EMPTY: if (comp) st_q <= HOLD_FULL;
        HOLD_FULL:  if (bus.word_ready && !comp) st_q <= HOLD_EMPTY;
        default:    st_q <= HOLD_EMPTY;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if ((st_q == HOLD_FULL) && !bus.word_ready && comp) ovr_q <= 1'b1;
      else if (bus.ovr_clr)                                ovr_q <= 1'b0;
    end
  end

  sipo_rx_reg_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .d_i    (sh_d),
    .q_o    (bus.word_out)
  );

  assign bus.word_valid = (st_q == HOLD_FULL);
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;

endmodule
